// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory loader: machine word width
// and the loader state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_FLUSH,
    ST_DONE,
    ST_ERR
  } load_state_e;

  // Byte address of word idx relative to base; 32-bit wrapping arithmetic.
  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] base,
                                                input logic [15:0] idx);
    return base + {14'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/byte_to_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_done marks the
// cycle in which the fourth byte is accepted and word holds the full value.
module byte_to_word_assembler
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            shift_en,
  input  logic [7:0]      byte_in,
  output logic [XLEN-1:0] word,
  output logic            word_done
);

  logic [1:0]  lane;
  logic [23:0] lanes_lo;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane <= 2'd0;
    end else if (shift_en) begin
      lane <= lane + 2'd1;
    end
  end

  // The top byte is never stored: it is forwarded straight into word.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      case (lane)
        2'd0:    lanes_lo[7:0]   <= byte_in;
        2'd1:    lanes_lo[15:8]  <= byte_in;
        2'd2:    lanes_lo[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

  assign word      = {byte_in, lanes_lo};
  assign word_done = shift_en && (lane == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory writer: parses a length-prefixed byte image, writes it
// word by word and keeps the core in reset until the image is complete.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic            byte_ready,
  output logic            imem_we,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] imem_wdata,
  output logic            cpu_reset_hold,
  output logic            busy,
  output logic            done,
  output logic            error
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

  load_state_e     state;
  logic [15:0]     n_words;
  logic [15:0]     word_idx;
  logic            hs;
  logic [15:0]     n_full;
  logic            asm_clear;
  logic            asm_shift;
  logic [XLEN-1:0] asm_word;
  logic            asm_done;

  assign hs        = byte_valid && byte_ready;
  assign n_full    = {byte_data, n_words[7:0]};
  assign asm_clear = (state == ST_HDR1);
  assign asm_shift = hs && (state == ST_DATA);

  byte_to_word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .shift_en  (asm_shift),
    .byte_in   (byte_data),
    .word      (asm_word),
    .word_done (asm_done)
  );

  // Outputs are assigned together with the state they belong to, so every
  // output reflects the state held in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      byte_ready     <= 1'b0;
      imem_we        <= 1'b0;
      imem_addr      <= BASE_ADDR;
      imem_wdata     <= '0;
      cpu_reset_hold <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      n_words        <= '0;
      word_idx       <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state          <= ST_HDR0;
            byte_ready     <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            cpu_reset_hold <= 1'b1;
          end
        end
        ST_HDR0: begin
          if (hs) begin
            n_words[7:0] <= byte_data;
            state        <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (hs) begin
            n_words[15:8] <= byte_data;
            if (n_full == 16'd0) begin
              state          <= ST_DONE;
              byte_ready     <= 1'b0;
              busy           <= 1'b0;
              done           <= 1'b1;
              cpu_reset_hold <= 1'b0;
            end else if ({1'b0, n_full} > DEPTH_L) begin
              state      <= ST_ERR;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              error      <= 1'b1;
            end else begin
              state    <= ST_DATA;
              word_idx <= '0;
            end
          end
        end
        ST_DATA: begin
          if (asm_done) begin
            imem_we    <= 1'b1;
            imem_wdata <= asm_word;
            imem_addr  <= word_addr(BASE_ADDR, word_idx);
            word_idx   <= word_idx + 16'd1;
            if (word_idx == n_words - 16'd1) begin
              state      <= ST_FLUSH;
              byte_ready <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          state          <= ST_DONE;
          busy           <= 1'b0;
          done           <= 1'b1;
          cpu_reset_hold <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header parsing, word assembly, write timing
// and the reset/start boundary behaviour.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset_hold;
  logic        busy;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          hs_cyc[$];

  imem_loader #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .byte_ready     (byte_ready),
    .imem_we        (imem_we),
    .imem_addr      (imem_addr),
    .imem_wdata     (imem_wdata),
    .cpu_reset_hold (cpu_reset_hold),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    hs_cyc.delete();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    acc        = 1'b0;
    byte_data  = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (byte_ready === 1'b1) acc = 1'b1;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    if (acc) hs_cyc.push_back(cyc);
    else begin
      total++; bad++;
      $display("FAIL send_byte_timeout got=byte_ready_low exp=handshake byte=%h", b);
    end
  endtask

  task automatic send_nominal(input int max_gap);
    logic [7:0] img [10];
    img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    for (int i = 0; i < 10; i++) begin
      send_byte(img[i]);
      if (max_gap > 0 && i < 9) repeat ($urandom_range(0, max_gap)) @(negedge clk);
    end
  endtask

  task automatic check_nominal_writes(input string tag);
    total++;
    if (wr_addr.size() !== 2) begin
      bad++; $display("FAIL %s_write_count got=%0d exp=2", tag, wr_addr.size());
    end else begin
      total++;
      if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h0010_0513) begin
        bad++; $display("FAIL %s_word0 got=%h@%h exp=00100513@00000000", tag, wr_data[0], wr_addr[0]);
      end
      total++;
      if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h0020_0593) begin
        bad++; $display("FAIL %s_word1 got=%h@%h exp=00200593@00000004", tag, wr_data[1], wr_addr[1]);
      end
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    do_reset(3);
    start = 1'b0;
    total++;
    if ({cpu_reset_hold, byte_ready, imem_we, done, error, busy} !== 6'b100000) begin
      bad++; $display("FAIL reset_flags got=%b exp=100000", {cpu_reset_hold, byte_ready, imem_we, done, error, busy});
    end
    total++;
    if (imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
      bad++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", imem_addr, imem_wdata);
    end
  endtask

  task automatic test_nominal();
    clear_log();
    pulse_start();
    total++;
    if (byte_ready !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL nominal_hdr0 got=rdy%b busy%b exp=rdy1 busy1", byte_ready, busy);
    end
    send_nominal(0);
    total++;
    if (imem_we !== 1'b1 || busy !== 1'b1 || byte_ready !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL nominal_flush got=we%b busy%b rdy%b done%b exp=we1 busy1 rdy0 done0", imem_we, busy, byte_ready, done);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || cpu_reset_hold !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL nominal_done got=done%b hold%b busy%b exp=done1 hold0 busy0", done, cpu_reset_hold, busy);
    end
    total++;
    if (imem_we !== 1'b0 || imem_addr !== 32'h4 || imem_wdata !== 32'h0020_0593) begin
      bad++; $display("FAIL nominal_hold_outputs got=we%b %h@%h exp=we0 00200593@00000004", imem_we, imem_wdata, imem_addr);
    end
    check_nominal_writes("nominal");
    total++;
    if (wr_cyc.size() == 2 && hs_cyc.size() == 10) begin
      if (wr_cyc[0] !== hs_cyc[5] || wr_cyc[1] !== hs_cyc[9]) begin
        bad++; $display("FAIL nominal_latency got=%0d,%0d exp=%0d,%0d", wr_cyc[0], wr_cyc[1], hs_cyc[5], hs_cyc[9]);
      end
    end else begin
      bad++; $display("FAIL nominal_latency got=writes%0d hs%0d exp=writes2 hs10", wr_cyc.size(), hs_cyc.size());
    end
  endtask

  task automatic test_empty();
    clear_log();
    pulse_start();
    total++;
    if (done !== 1'b0 || cpu_reset_hold !== 1'b1) begin
      bad++; $display("FAIL empty_restart got=done%b hold%b exp=done0 hold1", done, cpu_reset_hold);
    end
    send_byte(8'h00);
    send_byte(8'h00);
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    total++;
    if (byte_ready !== 1'b0) begin
      bad++; $display("FAIL empty_ready got=%b exp=0", byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    total++;
    if (done !== 1'b1 || cpu_reset_hold !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL empty_done got=done%b hold%b busy%b exp=done1 hold0 busy0", done, cpu_reset_hold, busy);
    end
    total++;
    if (wr_addr.size() !== 0) begin
      bad++; $display("FAIL empty_writes got=%0d exp=0", wr_addr.size());
    end
  endtask

  task automatic test_oversize();
    clear_log();
    pulse_start();
    send_byte(8'h41);
    send_byte(8'h00);
    byte_valid = 1'b1;
    byte_data  = 8'h13;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    total++;
    if ({error, byte_ready, busy, done, cpu_reset_hold} !== 5'b10001) begin
      bad++; $display("FAIL oversize_err got=%b exp=10001", {error, byte_ready, busy, done, cpu_reset_hold});
    end
    total++;
    if (wr_addr.size() !== 0) begin
      bad++; $display("FAIL oversize_writes got=%0d exp=0", wr_addr.size());
    end
    pulse_start();
    total++;
    if (error !== 1'b0 || busy !== 1'b1 || byte_ready !== 1'b1) begin
      bad++; $display("FAIL oversize_restart got=err%b busy%b rdy%b exp=err0 busy1 rdy1", error, busy, byte_ready);
    end
  endtask

  task automatic test_full_depth();
    logic [31:0] w;
    do_reset(1);
    clear_log();
    pulse_start();
    send_byte(8'h40);
    send_byte(8'h00);
    for (int i = 0; i < 64; i++) begin
      w = 32'h1000_0000 + i * 32'h0001_0203;
      send_byte(w[7:0]);
      send_byte(w[15:8]);
      send_byte(w[23:16]);
      send_byte(w[31:24]);
    end
    @(negedge clk);
    total++;
    if (error !== 1'b0 || done !== 1'b1) begin
      bad++; $display("FAIL full_done got=err%b done%b exp=err0 done1", error, done);
    end
    total++;
    if (wr_addr.size() !== 64) begin
      bad++; $display("FAIL full_count got=%0d exp=64", wr_addr.size());
    end else begin
      for (int i = 0; i < 64; i++) begin
        w = 32'h1000_0000 + i * 32'h0001_0203;
        total++;
        if (wr_addr[i] !== 32'(i * 4) || wr_data[i] !== w) begin
          bad++; $display("FAIL full_word%0d got=%h@%h exp=%h@%h", i, wr_data[i], wr_addr[i], w, 32'(i * 4));
        end
      end
    end
  endtask

  task automatic test_gapped();
    logic [7:0] img [10];
    img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    do_reset(1);
    clear_log();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      send_byte(img[i]);
      if (i == 4) begin
        pulse_start();
        total++;
        if (busy !== 1'b1 || cpu_reset_hold !== 1'b1 || byte_ready !== 1'b1) begin
          bad++; $display("FAIL gapped_start_ignored got=busy%b hold%b rdy%b exp=1 1 1", busy, cpu_reset_hold, byte_ready);
        end
      end
      if (i < 9) repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || cpu_reset_hold !== 1'b0) begin
      bad++; $display("FAIL gapped_done got=done%b hold%b exp=done1 hold0", done, cpu_reset_hold);
    end
    check_nominal_writes("gapped");
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    clear_log();
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'hEE);
    send_byte(8'hDD);
    send_byte(8'hCC);
    do_reset(1);
    total++;
    if ({cpu_reset_hold, byte_ready, imem_we, done, error, busy} !== 6'b100000) begin
      bad++; $display("FAIL midreset_flags got=%b exp=100000", {cpu_reset_hold, byte_ready, imem_we, done, error, busy});
    end
    total++;
    if (imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
      bad++; $display("FAIL midreset_addr_data got=%h/%h exp=0/0", imem_addr, imem_wdata);
    end
    byte_valid = 1'b1;
    byte_data  = 8'hFF;
    repeat (2) @(negedge clk);
    byte_valid = 1'b0;
    pulse_start();
    send_nominal(0);
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL midreset_done got=%b exp=1", done);
    end
    check_nominal_writes("reload");
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_empty();
    test_oversize();
    test_full_depth();
    test_gapped();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
